// File: rtl/vend_sequencer.sv
// Vending transaction controller: sequences an external balance register through
// coin collection, price check, item dispense and change hand-out.
module vend_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             coin_valid,
  input  logic [WIDTH-1:0] coin_value,
  input  logic             sel_valid,
  input  logic [WIDTH-1:0] sel_price,
  input  logic             cancel,
  input  logic             change_ack,
  input  logic [WIDTH-1:0] bal_q,
  output logic [WIDTH-1:0] bal_d,
  output logic             bal_load,
  output logic             dispense,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_value,
  output logic             busy,
  output logic             reject_coin,
  output logic             insufficient,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             reject_next;
  logic             insufficient_next;
  logic             load_req;
  logic [WIDTH:0]   coin_sum;

  // Change handshake: change_valid holds with a stable change_value until the
  // dispenser raises change_ack; the transfer completes on that clock edge.

  assign coin_sum = {1'b0, bal_q} + {1'b0, coin_value};

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      reject_coin  <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      state        <= state_next;
      reject_coin  <= reject_next;
      insufficient <= insufficient_next;
    end
  end

  always_comb begin
    state_next        = state;
    bal_d             = '0;
    load_req          = 1'b0;
    reject_next       = 1'b0;
    insufficient_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (cancel) begin
          reject_next = coin_valid;
        end else if (sel_valid) begin
          reject_next = coin_valid;
          if (sel_price == '0) state_next = DISPENSE;
          else                 insufficient_next = 1'b1;
        end else if (coin_valid) begin
          bal_d      = coin_value;
          load_req   = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          reject_next = coin_valid;
          state_next  = CHANGE;
        end else if (sel_valid) begin
          reject_next = coin_valid;
          if (bal_q >= sel_price) begin
            bal_d      = bal_q - sel_price;
            load_req   = 1'b1;
            state_next = DISPENSE;
          end else begin
            insufficient_next = 1'b1;
          end
        end else if (coin_valid) begin
          // A coin that would wrap the balance is handed back untouched.
          if (coin_sum[WIDTH]) begin
            reject_next = 1'b1;
          end else begin
            bal_d    = coin_sum[WIDTH-1:0];
            load_req = 1'b1;
          end
        end
      end
      DISPENSE: begin
        reject_next = coin_valid;
        state_next  = (bal_q == '0) ? IDLE : CHANGE;
      end
      CHANGE: begin
        reject_next = coin_valid;
        if (change_ack) begin
          bal_d      = '0;
          load_req   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The register shares our reset, so never request a load while it is held.
  assign bal_load     = load_req & ~reset;
  assign dispense     = (state == DISPENSE);
  assign change_valid = (state == CHANGE);
  assign change_value = (state == CHANGE) ? bal_q : '0;
  assign busy         = (state == DISPENSE) || (state == CHANGE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: models the balance register, drives strobes and
// checks balance, pulses and change amounts against a change scoreboard.
module tb_vend_sequencer;
  localparam int W = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DISPENSE = 2'd2, S_CHANGE = 2'd3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         coin_valid = 1'b0;
  logic [W-1:0] coin_value = '0;
  logic         sel_valid = 1'b0;
  logic [W-1:0] sel_price = '0;
  logic         cancel = 1'b0;
  logic         change_ack = 1'b0;
  logic [W-1:0] bal_q;
  logic [W-1:0] bal_d;
  logic         bal_load, dispense, change_valid, busy, reject_coin, insufficient;
  logic [W-1:0] change_value;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  int disp_cnt = 0;
  int chg_cnt = 0;
  logic [W-1:0] exp_q[$];

  vend_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_price(sel_price), .cancel(cancel), .change_ack(change_ack),
    .bal_q(bal_q), .bal_d(bal_d), .bal_load(bal_load), .dispense(dispense),
    .change_valid(change_valid), .change_value(change_value), .busy(busy),
    .reject_coin(reject_coin), .insufficient(insufficient), .state_dbg(state_dbg)
  );

  // clock / reset and the external balance register
  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (reset) bal_q <= '0;
    else if (bal_load) bal_q <= bal_d;
  end

  always @(negedge clock) begin
    if (dispense) disp_cnt++;
    if (change_valid) chg_cnt++;
  end

  // driver tasks: one cycle of strobes, outputs observed #1 after the edge
  task automatic drive(input logic cv, input logic [W-1:0] cval, input logic sv,
                       input logic [W-1:0] sp, input logic cn, input logic ak);
    coin_valid = cv; coin_value = cval; sel_valid = sv; sel_price = sp;
    cancel = cn; change_ack = ak;
    @(posedge clock); #1;
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; change_ack = 1'b0;
  endtask

  task automatic idle_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_change(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (change_valid) begin found = 1'b1; break; end
      idle_cycle();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bal_load !== 1'b0) begin errors++; $display("FAIL reset_bal_load got=%0b exp=0", bal_load); end
    reset = 1'b0;
    idle_cycle();
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_IDLE); end
    checks++; if ({dispense, change_valid, busy, reject_coin, insufficient} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got=%05b exp=00000", {dispense, change_valid, busy, reject_coin, insufficient}); end
    checks++; if (bal_q !== 8'd0) begin errors++; $display("FAIL reset_bal got=%0d exp=0", bal_q); end
  endtask

  task automatic test_purchase_with_change();
    logic found;
    int d0;
    d0 = disp_cnt;
    drive(1'b1, 8'd5, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (bal_q !== 8'd5) begin errors++; $display("FAIL buy_coin1 got=%0d exp=5", bal_q); end
    drive(1'b1, 8'd10, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (bal_q !== 8'd15) begin errors++; $display("FAIL buy_coin2 got=%0d exp=15", bal_q); end
    drive(1'b0, '0, 1'b1, 8'd12, 1'b0, 1'b0);
    exp_q.push_back(8'd3);
    checks++; if (bal_q !== 8'd3) begin errors++; $display("FAIL buy_bal got=%0d exp=3", bal_q); end
    checks++; if ({dispense, busy} !== 2'b11) begin errors++; $display("FAIL buy_dispense got=%02b exp=11", {dispense, busy}); end
    wait_change(found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL buy_change_timeout got=0 exp=1"); end
    if (found) begin
      checks++; if (change_value !== exp_q[0]) begin errors++; $display("FAIL buy_change_value got=%0d exp=%0d", change_value, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (disp_cnt - d0 !== 1) begin errors++; $display("FAIL buy_dispense_len got=%0d exp=1", disp_cnt - d0); end
    idle_cycle();
    checks++; if (change_valid !== 1'b1) begin errors++; $display("FAIL buy_change_hold got=%0b exp=1", change_valid); end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    checks++; if (bal_q !== 8'd0) begin errors++; $display("FAIL buy_ack_bal got=%0d exp=0", bal_q); end
    checks++; if ({state_dbg, change_valid} !== {S_IDLE, 1'b0}) begin
      errors++; $display("FAIL buy_ack_state got=%0d/%0b exp=0/0", state_dbg, change_valid); end
  endtask

  task automatic test_exact_change();
    int d0, c0;
    d0 = disp_cnt; c0 = chg_cnt;
    drive(1'b1, 8'd20, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 8'd20, 1'b0, 1'b0);
    checks++; if ({state_dbg, bal_q} !== {S_DISPENSE, 8'd0}) begin
      errors++; $display("FAIL exact_dispense got=%0d/%0d exp=2/0", state_dbg, bal_q); end
    idle_cycle();
    idle_cycle();
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL exact_state got=%0d exp=0", state_dbg); end
    checks++; if (chg_cnt !== c0 || disp_cnt - d0 !== 1) begin
      errors++; $display("FAIL exact_counts got=chg%0d/disp%0d exp=0/1", chg_cnt - c0, disp_cnt - d0); end
  endtask

  task automatic test_insufficient();
    logic found;
    drive(1'b1, 8'd10, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 8'd25, 1'b0, 1'b0);
    checks++; if ({insufficient, bal_q, state_dbg} !== {1'b1, 8'd10, S_COLLECT}) begin
      errors++; $display("FAIL insuf_pulse got=%0b/%0d/%0d exp=1/10/1", insufficient, bal_q, state_dbg); end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    checks++; if ({insufficient, bal_q, state_dbg} !== {1'b0, 8'd10, S_COLLECT}) begin
      errors++; $display("FAIL insuf_stray_ack got=%0b/%0d/%0d exp=0/10/1", insufficient, bal_q, state_dbg); end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    exp_q.push_back(8'd10);
    wait_change(found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL insuf_change_timeout got=0 exp=1"); end
    if (found) begin
      checks++; if (change_value !== exp_q[0]) begin errors++; $display("FAIL insuf_change_value got=%0d exp=%0d", change_value, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    checks++; if (bal_q !== 8'd0) begin errors++; $display("FAIL insuf_ack_bal got=%0d exp=0", bal_q); end
  endtask

  task automatic test_overflow();
    logic found;
    drive(1'b1, 8'd200, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 8'd100, 1'b0, '0, 1'b0, 1'b0);
    checks++; if ({reject_coin, bal_q} !== {1'b1, 8'd200}) begin
      errors++; $display("FAIL ovf_reject got=%0b/%0d exp=1/200", reject_coin, bal_q); end
    drive(1'b1, 8'd55, 1'b0, '0, 1'b0, 1'b0);
    checks++; if ({reject_coin, bal_q} !== {1'b0, 8'd255}) begin
      errors++; $display("FAIL ovf_fill got=%0b/%0d exp=0/255", reject_coin, bal_q); end
    drive(1'b1, 8'd1, 1'b0, '0, 1'b0, 1'b0);
    checks++; if ({reject_coin, bal_q} !== {1'b1, 8'd255}) begin
      errors++; $display("FAIL ovf_max_plus1 got=%0b/%0d exp=1/255", reject_coin, bal_q); end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    exp_q.push_back(8'd255);
    wait_change(found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL ovf_change_timeout got=0 exp=1"); end
    if (found) begin
      checks++; if (change_value !== exp_q[0]) begin errors++; $display("FAIL ovf_change_value got=%0d exp=%0d", change_value, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_priority();
    logic found;
    int d0;
    drive(1'b1, 8'd10, 1'b0, '0, 1'b0, 1'b0);
    d0 = disp_cnt;
    drive(1'b1, 8'd5, 1'b1, 8'd5, 1'b1, 1'b0);
    exp_q.push_back(8'd10);
    checks++; if ({reject_coin, insufficient, state_dbg} !== {1'b1, 1'b0, S_CHANGE}) begin
      errors++; $display("FAIL prio_cancel got=%0b/%0b/%0d exp=1/0/3", reject_coin, insufficient, state_dbg); end
    wait_change(found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL prio_change_timeout got=0 exp=1"); end
    if (found) begin
      checks++; if (change_value !== exp_q[0]) begin errors++; $display("FAIL prio_change_value got=%0d exp=%0d", change_value, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    checks++; if (disp_cnt !== d0) begin errors++; $display("FAIL prio_no_dispense got=%0d exp=0", disp_cnt - d0); end
  endtask

  task automatic test_free_item();
    drive(1'b0, '0, 1'b1, 8'd0, 1'b0, 1'b0);
    checks++; if ({dispense, insufficient, bal_q} !== {1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL free_dispense got=%0b/%0b/%0d exp=1/0/0", dispense, insufficient, bal_q); end
    idle_cycle();
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL free_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_back_to_back();
    logic found;
    logic [W-1:0] model_bal;
    logic [W-1:0] cv;
    logic exp_rej;
    drive(1'b1, 8'd1, 1'b0, '0, 1'b0, 1'b0);
    model_bal = 8'd1;
    for (int i = 0; i < 16; i++) begin
      cv = W'($urandom_range(0, 60));
      exp_rej = (int'(model_bal) + int'(cv)) > 255;
      if (!exp_rej) model_bal = model_bal + cv;
      drive(1'b1, cv, 1'b0, '0, 1'b0, 1'b0);
      checks++; if ({reject_coin, bal_q} !== {exp_rej, model_bal}) begin
        errors++; $display("FAIL b2b_coin%0d got=%0b/%0d exp=%0b/%0d", i, reject_coin, bal_q, exp_rej, model_bal); end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    exp_q.push_back(model_bal);
    wait_change(found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL b2b_change_timeout got=0 exp=1"); end
    if (found) begin
      drive(1'b1, 8'd3, 1'b0, '0, 1'b0, 1'b0);
      checks++; if ({reject_coin, change_value} !== {1'b1, exp_q[0]}) begin
        errors++; $display("FAIL b2b_change got=%0b/%0d exp=1/%0d", reject_coin, change_value, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_in_change();
    int c0;
    drive(1'b1, 8'd10, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 8'd4, 1'b0, 1'b0);
    idle_cycle();
    checks++; if (state_dbg !== S_CHANGE) begin errors++; $display("FAIL rst_chg_enter got=%0d exp=3", state_dbg); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if ({dispense, change_valid, change_value, busy, reject_coin, insufficient, bal_load, bal_q, state_dbg} !==
                  {5'b0, 8'd0, 2'b0, 8'd0, S_IDLE}) begin
      errors++; $display("FAIL rst_chg_outputs got=%0b%0b/%0d/%0b%0b%0b%0b/%0d/%0d exp=all zero, idle",
                         dispense, change_valid, change_value, busy, reject_coin, insufficient, bal_load, bal_q, state_dbg); end
    c0 = chg_cnt;
    repeat (5) idle_cycle();
    checks++; if (chg_cnt !== c0) begin errors++; $display("FAIL rst_chg_no_change got=%0d exp=0", chg_cnt - c0); end
  endtask

  initial begin
    test_reset();
    test_purchase_with_change();
    test_exact_change();
    test_insufficient();
    test_overflow();
    test_priority();
    test_free_item();
    test_back_to_back();
    test_reset_in_change();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
